// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding and FSM states.
// Ops 6 and 7 are no-ops.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // Multi-cycle ops are the ones that run the iterative datapath.
    function automatic logic isArithOp(input logic [2:0] op);
        return op <= OP_DIVU;
    endfunction

    function automatic logic isSignedOp(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Pipeline-facing bundle of the HI/LO multiply/divide unit.
// Handshake: a request (start/op/a/b) is taken on a rising edge where busy=0 and cancel=0; otherwise it is dropped and must be re-presented.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    state_e           dbgState;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo, dbgState
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo, dbgState
    );

endinterface

// File: rtl/hilo_muldiv_unit_signfix.sv
// Conditional two's-complement negate; yields |x| when neg = sign bit,
// and restores a result's sign when neg = result sign flag.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO pair.
// Operands run as magnitudes; signs are reapplied in FIN.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    hilo_muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             stateQ;
    state_e             stateD;
    logic [CNT_W-1:0]   cntQ;
    logic [2*WIDTH-1:0] accQ;
    logic [WIDTH-1:0]   remQ;
    logic [WIDTH-1:0]   opndQ;
    logic [WIDTH-1:0]   hiQ;
    logic [WIDTH-1:0]   loQ;
    logic               isDivQ;
    logic               resNegQ;
    logic               remNegQ;
    logic               doneQ;

    logic               accept;
    logic               signedOp;
    logic               finWrite;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     trial;
    logic               divGe;
    logic [WIDTH-1:0]   remNext;

    assign accept   = (stateQ == S_IDLE) && bus.start && !bus.cancel;
    assign signedOp = isSignedOp(bus.op);
    // A flush arriving in FIN suppresses the architectural write.
    assign finWrite = (stateQ == S_FIN) && !bus.cancel;

    muldiv_signfix #(.WIDTH(WIDTH)) uAbsA (
        .val (bus.a),
        .neg (signedOp && bus.a[WIDTH-1]),
        .res (aMag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) uAbsB (
        .val (bus.b),
        .neg (signedOp && bus.b[WIDTH-1]),
        .res (bMag)
    );

    muldiv_signfix #(.WIDTH(2*WIDTH)) uFixProd (
        .val (accQ),
        .neg (resNegQ),
        .res (prodFix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) uFixQuo (
        .val (accQ[WIDTH-1:0]),
        .neg (resNegQ),
        .res (quoFix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) uFixRem (
        .val (remQ),
        .neg (remNegQ),
        .res (remFix)
    );

    // Multiply: accQ = {partial product, remaining multiplier bits}, shifted right each step.
    assign mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opndQ} : '0);
    assign mulNext = {mulSum, accQ[WIDTH-1:1]};

    // Divide: accQ low half shifts dividend bits out and quotient bits in.
    assign trial   = {remQ, accQ[WIDTH-1]};
    assign divGe   = trial >= {1'b0, opndQ};
    assign remNext = divGe ? (trial[WIDTH-1:0] - opndQ) : trial[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= S_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            S_IDLE: begin
                if (accept && isArithOp(bus.op)) begin
                    stateD = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    stateD = S_IDLE;
                end else if (cntQ == CNT_W'(1)) begin
                    stateD = S_FIN;
                end
            end
            S_FIN:   stateD = S_IDLE;
            default: stateD = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntQ    <= '0;
            accQ    <= '0;
            remQ    <= '0;
            opndQ   <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            isDivQ  <= 1'b0;
            resNegQ <= 1'b0;
            remNegQ <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            doneQ <= finWrite;
            if (accept) begin
                case (bus.op)
                    OP_MTHI: hiQ <= bus.a;
                    OP_MTLO: loQ <= bus.a;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        accQ    <= {{WIDTH{1'b0}}, aMag};
                        opndQ   <= bMag;
                        remQ    <= '0;
                        cntQ    <= CNT_W'(WIDTH);
                        isDivQ  <= bus.op[1];
                        // Divide by zero keeps the all-ones quotient unsigned so hi/lo come out as {a, ~0}.
                        resNegQ <= signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                                   && (!bus.op[1] || (bus.b != '0));
                        remNegQ <= signedOp && bus.a[WIDTH-1];
                    end
                    default: ;
                endcase
            end else if (stateQ == S_CALC) begin
                cntQ <= cntQ - 1'b1;
                if (isDivQ) begin
                    accQ[WIDTH-1:0] <= {accQ[WIDTH-2:0], divGe};
                    remQ            <= remNext;
                end else begin
                    accQ <= mulNext;
                end
            end else if (finWrite) begin
                if (isDivQ) begin
                    loQ <= quoFix;
                    hiQ <= remFix;
                end else begin
                    {hiQ, loQ} <= prodFix;
                end
            end
        end
    end

    assign bus.busy     = (stateQ != S_IDLE);
    assign bus.done     = doneQ;
    assign bus.hi       = hiQ;
    assign bus.lo       = loQ;
    assign bus.dbgState = stateQ;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations per vector.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nVec = 0;
    int nErr = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, pending result.
    logic [W-1:0]   expHi   = '0;
    logic [W-1:0]   expLo   = '0;
    logic           expDone = 1'b0;
    int             left    = 0;
    logic [2*W-1:0] pending = '0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        nVec++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [2*W-1:0] refResult(input logic [2:0] op, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [2*W-1:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        u  = '0;
        case (op)
            OP_MULT:  begin q = sx * sy; u = q; end
            OP_MULTU: u = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            OP_DIV: begin
                if (y == '0) u = {x, {W{1'b1}}};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    u = {r[W-1:0], q[W-1:0]};
                end
            end
            OP_DIVU: begin
                if (y == '0) u = {x, {W{1'b1}}};
                else u = {x % y, x / y};
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            expHi   = '0;
            expLo   = '0;
            expDone = 1'b0;
            left    = 0;
        end else begin
            expDone = 1'b0;
            if (left > 0) begin
                if (bus.cancel) begin
                    left = 0;
                end else begin
                    left--;
                    if (left == 0) begin
                        {expHi, expLo} = pending;
                        expDone = 1'b1;
                    end
                end
            end else if (bus.start && !bus.cancel) begin
                case (bus.op)
                    OP_MTHI: expHi = bus.a;
                    OP_MTLO: expLo = bus.a;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        pending = refResult(bus.op, bus.a, bus.b);
                        left    = W + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("cyc_busy", bus.busy, left > 0);
            check("cyc_done", bus.done, expDone);
            check("cyc_hi", bus.hi, expHi);
            check("cyc_lo", bus.lo, expLo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk); #1;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            nVec++;
            nErr++;
            $display("FAIL done_timeout: got no done within %0d cycles, want done", cyc);
        end
    endtask

    task automatic runArith(input string name, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] wantHi,
                            input logic [W-1:0] wantLo);
        int cyc;
        issue(o, x, y);
        waitDone(cyc);
        check({name, "_lat"}, cyc, W + 2);
        check({name, "_hi"}, bus.hi, wantHi);
        check({name, "_lo"}, bus.lo, wantLo);
        check({name, "_model_hi"}, expHi, wantHi);
        check({name, "_model_lo"}, expLo, wantLo);
        @(negedge clk); #1;
        check({name, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int cyc;
        int doneSeen;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        rst        = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_state", bus.dbgState, S_IDLE);
        rst = 1'b1;

        runArith("mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        runArith("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runArith("mult_mix",   OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runArith("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        runArith("div_negb",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        runArith("divu_zero",  OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        runArith("div_zero",   OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
        runArith("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        runArith("divu_plain", OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);

        // MTHI lands the next cycle without a busy stall.
        issue(OP_MTHI, 32'h12345678, 32'd0);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_busy", bus.busy, 1'b0);

        // MTLO presented mid-multiply is dropped.
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = OP_MTLO;
        bus.a     = 32'hDEADBEEF;
        @(negedge clk); #1;
        bus.start = 1'b0;
        check("mtlo_busy_lo", bus.lo, 32'h0000000E);
        check("mtlo_busy_busy", bus.busy, 1'b1);
        waitDone(cyc);
        check("mult_after_mtlo_hi", bus.hi, 32'h00000000);
        check("mult_after_mtlo_lo", bus.lo, 32'h0000002A);

        // Cancel a divide at cycle 10.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #1;
        bus.cancel = 1'b1;
        @(negedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 1'b0);
        check("cancel_hi", bus.hi, 32'h00000000);
        check("cancel_lo", bus.lo, 32'h0000002A);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        check("cancel_no_done", doneSeen, 0);

        // Cancel landing on the FIN cycle (cycle 33) wins over the write.
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (32) @(negedge clk);
        #1;
        bus.cancel = 1'b1;
        @(negedge clk); #1;
        bus.cancel = 1'b0;
        check("finc_done", bus.done, 1'b0);
        check("finc_lo", bus.lo, 32'h0000002A);
        check("finc_busy", bus.busy, 1'b0);

        // Cancel in IDLE suppresses the start.
        @(negedge clk); #1;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = OP_MTHI;
        bus.a      = 32'h0000CAFE;
        @(negedge clk); #1;
        bus.op = OP_MULT;
        @(negedge clk); #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("idlec_hi", bus.hi, 32'h00000000);
        check("idlec_busy", bus.busy, 1'b0);

        // Reset mid-divide at cycle 20 clears everything at once.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_busy", bus.busy, 1'b0);
        check("rstmid_hi", bus.hi, 32'h00000000);
        check("rstmid_lo", bus.lo, 32'h00000000);
        check("rstmid_done", bus.done, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;

        runArith("mult_post", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS pipeline.
- Replaces the single-cycle HI/LO write path with iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
- Sits beside the execute-stage ALU; asserts busy so the hazard unit stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- start, in, 1, issue request, sampled only when busy=0.
- op, in, 3, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- a, in, WIDTH, rs operand (dividend/multiplicand; MTHI/MTLO source).
- b, in, WIDTH, rt operand (divisor/multiplier).
- cancel, in, 1, flush; aborts an in-flight operation.
- busy, out, 1, operation in flight; stall request.
- done, out, 1, one-cycle pulse on the cycle HI/LO take a MULT/DIV result.
- hi, out, WIDTH, architectural HI register.
- lo, out, WIDTH, architectural LO register.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers 0.
- States: IDLE, CALC, FIN. busy = (state != IDLE). done is registered and high only in the cycle after FIN.
- In IDLE with start=1, cancel=0:
  - MTHI writes hi<=a on that edge; MTLO writes lo<=a. Single cycle, busy stays 0.
  - op 6/7: no effect.
  - op 0-3: latch operand magnitudes (|a|,|b| for signed ops, raw for unsigned), result sign flags and op, counter<=WIDTH; go to CALC.
- CALC: one radix-2 step per cycle, counter decrements.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits.
  - Go to FIN when counter reaches 1 after its step, i.e. exactly WIDTH CALC cycles.
- FIN: apply two's-complement sign fix-up, write hi/lo, return to IDLE.
  - Multiply: {hi,lo} = 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Timing: start edge at cycle 0; busy=1 for cycles 1..WIDTH+1; hi/lo updated and done=1 visible in cycle WIDTH+2.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow (min / -1): lo = min (0x80000000 at WIDTH=32), hi=0. This falls out of the magnitude path and needs no special case.
- Divide by zero, both DIV and DIVU: lo = all ones, hi = a (raw dividend). Full WIDTH-cycle latency still applies.
- Requests while busy=1: start ignored, including MTHI/MTLO. The pipeline is stalled, so the request is re-presented later.
- cancel=1 while busy=1: next state IDLE; hi/lo unchanged; no done.
- cancel=1 in IDLE: start that cycle is suppressed.
- cancel and FIN in the same cycle: cancel wins; hi/lo are not written.
- Reset asserted mid-operation: immediate return to the reset state; no partial HI/LO write.
- Operands are sampled only at accept; later changes on a/b are ignored.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants (OP_MULT..OP_MTLO);
  - state enum (S_IDLE, S_CALC, S_FIN).
- One sub-module is natural: muldiv_signfix, a combinational magnitude/negate helper parametrised by WIDTH. It is used both at operand latch and at result fix-up.
- Everything else stays in hilo_muldiv_unit.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFE, b=3 -> at cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for one cycle; busy=1 over cycles 1-33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. MTLO presented while busy -> lo unchanged.
- Start DIV, cancel at cycle 10 -> busy=0 at cycle 11, hi/lo keep prior values, no done. Repeat with rst=0 at cycle 20 -> hi=lo=0, busy=0 immediately.
